kb_scan_ctrl: RTL and testbench

Matrix-keyboard scan controller that sequences column drive and row sampling for the 5-row keypad feeding the board's keyboard path. It debounces one key at a time, encodes it as a key code, and hands it to the consumer (hex display path or later logic) over a valid/ready handshake. It replaces free-running row sampling on a divided clock with a deterministic, single-clock scan schedule.

---
 rtl/kb_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_kb_scan_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_scan_ctrl.sv
// kb_scan_ctrl: matrix keypad scanner. Drives one column low at a time,
// samples the synchronised rows after a settle dwell, debounces a single
// key for press and release, and presents its code on a valid/ready port.
module kb_scan_ctrl #(
    parameter int N_ROW      = 5,
    parameter int N_COL      = 4,
    parameter int SETTLE     = 1000,
    parameter int DEB_CYCLES = 100000,
    parameter int CODE_W     = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_ROW-1:0]  K_ROW,
    output logic [N_COL-1:0]  K_COL,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int ROW_W   = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int COL_W   = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int DWELL_W = $clog2(SETTLE);
    localparam int DEB_W   = $clog2(DEB_CYCLES);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESS    = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [N_COL-1:0]   COL_ONE    = N_COL'(1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(N_COL - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SETTLE - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);

    logic [N_ROW-1:0]   r_sync1;
    logic [N_ROW-1:0]   r_sync2;
    logic [1:0]         r_state;
    logic [COL_W-1:0]   r_col_idx;
    logic [N_COL-1:0]   r_col_drv;
    logic [DWELL_W-1:0] r_dwell;
    logic [DEB_W-1:0]   r_deb_cnt;
    logic [ROW_W-1:0]   r_cap_row;
    logic [CODE_W-1:0]  r_key_code;
    logic               r_key_valid;
    logic               r_overrun;

    logic [COL_W-1:0]   w_next_col;
    logic [N_COL-1:0]   w_next_drv;
    logic [ROW_W-1:0]   w_low_row;
    logic               w_all_high;
    logic               w_trk_high;
    logic               w_hs;
    logic [CODE_W-1:0]  w_press_code;

    assign w_next_col   = (r_col_idx == COL_LAST) ? '0 : r_col_idx + 1'b1;
    assign w_next_drv   = ~(COL_ONE << w_next_col);
    assign w_all_high   = &r_sync2;
    // While debouncing/releasing the column never moves, so r_col_idx is the captured column.
    assign w_trk_high   = r_sync2[r_cap_row];
    assign w_hs         = r_key_valid && key_ready;
    assign w_press_code = CODE_W'(r_cap_row) * CODE_W'(N_COL) + CODE_W'(r_col_idx);

    // Lowest-index closed row on the driven column wins when several are low.
    always_comb begin
        // NOTE: default assignment first so every path writes w_low_row and no latch is inferred.
        w_low_row = '0;
        for (int i = N_ROW - 1; i >= 0; i--) begin
            if (!r_sync2[i]) w_low_row = ROW_W'(i);
        end
    end

    // Two-flop synchroniser for the asynchronous row lines; idle rows read high.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= K_ROW;
            r_sync2 <= r_sync1;
        end
    end

    // Scan / debounce / press / release sequencer with column drive.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_SCAN;
            r_col_idx <= '0;
            r_col_drv <= ~COL_ONE;
            r_dwell   <= '0;
            r_deb_cnt <= '0;
            r_cap_row <= '0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        if (w_all_high) begin
                            r_col_idx <= w_next_col;
                            r_col_drv <= w_next_drv;
                        end else begin
                            r_cap_row <= w_low_row;
                            r_deb_cnt <= '0;
                            r_state   <= ST_DEBOUNCE;
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_trk_high) begin
                        if (r_deb_cnt == DEB_LAST) r_state <= ST_PRESS;
                        else                       r_deb_cnt <= r_deb_cnt + 1'b1;
                    end else begin
                        // Glitch: drop the candidate and move on to the next column.
                        r_state   <= ST_SCAN;
                        r_col_idx <= w_next_col;
                        r_col_drv <= w_next_drv;
                        r_dwell   <= '0;
                    end
                end
                ST_PRESS: begin
                    r_deb_cnt <= '0;
                    r_state   <= ST_RELEASE;
                end
                default: begin
                    if (w_trk_high) begin
                        if (r_deb_cnt == DEB_LAST) begin
                            r_state   <= ST_SCAN;
                            r_col_idx <= w_next_col;
                            r_col_drv <= w_next_drv;
                            r_dwell   <= '0;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + 1'b1;
                        end
                    end else begin
                        r_deb_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Output key register: PRESS loads a new code (newest wins), handshake consumes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
        end else if (r_state == ST_PRESS) begin
            r_key_code  <= w_press_code;
            r_key_valid <= 1'b1;
        end else if (w_hs) begin
            r_key_valid <= 1'b0;
        end
    end

    // Sticky overrun: a press landed on an unconsumed key; set beats clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overrun <= 1'b0;
        end else if ((r_state == ST_PRESS) && r_key_valid && !key_ready) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign K_COL     = r_col_drv;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// tb_kb_scan_ctrl: keypad model driving kb_scan_ctrl with a directed table,
// hand-written corner sequences and a randomized chord phase scored against
// expected key codes derived from the row/column of each chord.
module tb_kb_scan_ctrl;

    localparam int N_ROW  = 5;
    localparam int N_COL  = 4;
    localparam int SETTLE = 4;
    localparam int DEB    = 8;
    localparam int CODE_W = 5;
    localparam int REL_WAIT = 2 * DEB + 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic [N_ROW-1:0]  K_ROW;
    logic [N_COL-1:0]  K_COL;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready = 1'b0;
    logic              overrun;
    logic              overrun_clr = 1'b0;

    // pressed[c][r] = 1 means the key at row r / column c is closed.
    logic [N_ROW-1:0]  pressed [N_COL] = '{default: '0};

    int checks   = 0;
    int failures = 0;
    bit sb_en      = 1'b0;
    bit rand_ready = 1'b0;
    int sb_q [$];

    typedef struct {
        logic [N_ROW-1:0] mask;
        int               col;
        int               exp_code;
    } vec_t;

    vec_t vecs [7];

    kb_scan_ctrl #(
        .N_ROW(N_ROW), .N_COL(N_COL), .SETTLE(SETTLE),
        .DEB_CYCLES(DEB), .CODE_W(CODE_W)
    ) dut (
        .clk(clk), .rstn(rstn), .K_ROW(K_ROW), .K_COL(K_COL),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    // Passive keypad: a closed key pulls its row low only while its column is driven low.
    always_comb begin
        K_ROW = '1;
        for (int c = 0; c < N_COL; c++) begin
            if (!K_COL[c]) K_ROW = K_ROW & ~pressed[c];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N_COL-1:0] drv_of(input int col);
        logic [N_COL-1:0] d;
        d = '1;
        d[col] = 1'b0;
        return d;
    endfunction

    function automatic int code_of(input logic [N_ROW-1:0] mask, input int col);
        for (int r = 0; r < N_ROW; r++) begin
            if (mask[r]) return r * N_COL + col;
        end
        return -1;
    endfunction

    // One clock: note any handshake at the coming edge, advance to the next negedge.
    task automatic tick();
        logic              hs;
        logic [CODE_W-1:0] code_at_edge;
        hs = key_valid && key_ready;
        code_at_edge = key_code;
        @(posedge clk);
        @(negedge clk);
        if (sb_en && hs) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_key: got code %0d with no key expected", code_at_edge);
            end else begin
                check("rand_code", 32'(code_at_edge), 32'(sb_q.pop_front()));
            end
        end
        if (rand_ready) key_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!key_valid && n < budget) begin tick(); n++; end
        check(name, 32'(key_valid), 32'd1);
    endtask

    task automatic wait_col(input string name, input logic [N_COL-1:0] exp, input int budget);
        int n = 0;
        while (K_COL !== exp && n < budget) begin tick(); n++; end
        check(name, 32'(K_COL), 32'(exp));
    endtask

    task automatic wait_leave(input logic [N_COL-1:0] from, input int budget, output int n);
        n = 0;
        while (K_COL === from && n < budget) begin tick(); n++; end
    endtask

    task automatic quiet(input string name, input int cycles);
        logic saw = 1'b0;
        repeat (cycles) begin
            tick();
            if (key_valid) saw = 1'b1;
        end
        check(name, 32'(saw), 32'd0);
    endtask

    task automatic consume();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_kcol"},    32'(K_COL),     32'(drv_of(0)));
        check({tag, "_valid"},   32'(key_valid), 32'd0);
        check({tag, "_code"},    32'(key_code),  32'd0);
        check({tag, "_overrun"}, 32'(overrun),   32'd0);
    endtask

    initial begin
        int n;
        logic saw_bad;

        vecs[0] = '{mask: 5'b00100, col: 1, exp_code: 9};
        vecs[1] = '{mask: 5'b00001, col: 3, exp_code: 3};
        vecs[2] = '{mask: 5'b10000, col: 3, exp_code: 19};
        vecs[3] = '{mask: 5'b11111, col: 0, exp_code: 0};
        vecs[4] = '{mask: 5'b11000, col: 2, exp_code: 14};
        vecs[5] = '{mask: 5'b00010, col: 0, exp_code: 4};
        vecs[6] = '{mask: 5'b10100, col: 1, exp_code: 9};

        // ---- reset values, then idle scan: each column held SETTLE cycles, wrapping
        #1 rstn = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        saw_bad = 1'b0;
        check("scan_0", 32'(K_COL), 32'(drv_of(0)));
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("scan_%0d", k), 32'(K_COL), 32'(drv_of((k / SETTLE) % N_COL)));
            if (key_valid || overrun) saw_bad = 1'b1;
        end
        check("scan_idle_outputs", 32'(saw_bad), 32'd0);

        // ---- row2/col1 latency: SETTLE-2 cycles to the deciding raw capture, then 2 sync + DEB + PRESS
        pressed[1][2] = 1'b1;
        wait_col("lat_col1", drv_of(1), 40);
        n = 0;
        while (!key_valid && n < 60) begin tick(); n++; end
        check("press_latency", 32'(n), 32'(SETTLE + DEB + 1));
        check("press_code_9", 32'(key_code), 32'd9);
        consume();
        check("handshake_clears", 32'(key_valid), 32'd0);
        quiet("held_no_repeat", 40);
        check("held_col_kept", 32'(K_COL), 32'(drv_of(1)));
        pressed[1][2] = 1'b0;
        wait_leave(drv_of(1), 40, n);
        check("release_latency", 32'(n), 32'(2 + DEB));
        check("resume_col2", 32'(K_COL), 32'(drv_of(2)));

        // ---- bounce on row0/col3 during debounce: no key, next column is col0
        pressed[3][0] = 1'b1;
        wait_col("bounce_col3", drv_of(3), 40);
        repeat (SETTLE) tick();
        repeat (4) tick();
        pressed[3][0] = 1'b0;
        tick();
        pressed[3][0] = 1'b1;
        wait_leave(drv_of(3), 10, n);
        check("bounce_to_col0", 32'(K_COL), 32'(drv_of(0)));
        repeat (3) tick();
        pressed[3][0] = 1'b0;
        quiet("bounce_no_key", 60);

        // ---- two presses without key_ready: newest code wins, overrun sticks until cleared
        pressed[1][2] = 1'b1;
        wait_valid("ovr_first_valid", 100);
        check("ovr_first_code", 32'(key_code), 32'd9);
        pressed[1][2] = 1'b0;
        repeat (REL_WAIT) tick();
        check("ovr_not_yet", 32'(overrun), 32'd0);
        pressed[0][4] = 1'b1;
        n = 0;
        while (key_code !== 5'd16 && n < 80) begin tick(); n++; end
        check("ovr_second_code", 32'(key_code), 32'd16);
        check("ovr_valid_kept", 32'(key_valid), 32'd1);
        check("ovr_set", 32'(overrun), 32'd1);
        pressed[0][4] = 1'b0;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        check("ovr_clr_valid_kept", 32'(key_valid), 32'd1);
        check("ovr_clr_code_kept", 32'(key_code), 32'd16);
        consume();
        check("ovr_consumed", 32'(key_valid), 32'd0);
        repeat (REL_WAIT) tick();

        // ---- directed table of single-column chords
        for (int i = 0; i < $size(vecs); i++) begin
            pressed[vecs[i].col] = vecs[i].mask;
            wait_valid($sformatf("tbl%0d_valid", i), 100);
            check($sformatf("tbl%0d_code", i), 32'(key_code), 32'(vecs[i].exp_code));
            consume();
            check($sformatf("tbl%0d_consumed", i), 32'(key_valid), 32'd0);
            pressed[vecs[i].col] = '0;
            repeat (REL_WAIT) tick();
        end

        // ---- rows 1 and 3 on col2: code 6, releasing row1 alone ends the hold
        pressed[2] = 5'b01010;
        wait_valid("dual_valid", 100);
        check("dual_code", 32'(key_code), 32'd6);
        consume();
        repeat (10) tick();
        check("dual_held", 32'(K_COL), 32'(drv_of(2)));
        pressed[2][1] = 1'b0;
        wait_leave(drv_of(2), 40, n);
        check("dual_release_done", 32'(K_COL), 32'(drv_of(3)));
        pressed[2] = '0;
        quiet("dual_no_extra", 40);

        // ---- randomized chords with a randomly stalling consumer
        sb_en = 1'b1;
        rand_ready = 1'b1;
        for (int it = 0; it < 16; it++) begin
            int               col;
            logic [N_ROW-1:0] mask;
            col  = $urandom_range(0, N_COL - 1);
            mask = N_ROW'($urandom_range(1, (1 << N_ROW) - 1));
            sb_q.push_back(code_of(mask, col));
            pressed[col] = mask;
            n = 0;
            while (sb_q.size() != 0 && n < 300) begin tick(); n++; end
            check($sformatf("rand%0d_consumed", it), 32'(sb_q.size()), 32'd0);
            sb_q.delete();
            repeat ($urandom_range(0, 15)) tick();
            pressed[col] = '0;
            repeat (REL_WAIT) tick();
        end
        rand_ready = 1'b0;
        key_ready = 1'b0;
        tick();
        sb_en = 1'b0;
        check("rand_no_overrun", 32'(overrun), 32'd0);
        check("rand_idle_valid", 32'(key_valid), 32'd0);

        // ---- reset mid-debounce
        pressed[1][2] = 1'b1;
        wait_col("rst_deb_col1", drv_of(1), 40);
        repeat (SETTLE + 3) tick();
        #2 rstn = 1'b0;
        #1 check_reset_outputs("rst_deb");
        pressed[1][2] = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        quiet("rst_deb_no_key", 60);

        // ---- reset mid-release with a pending key and overrun set
        pressed[1][2] = 1'b1;
        wait_valid("rst_rel_first", 100);
        pressed[1][2] = 1'b0;
        repeat (REL_WAIT) tick();
        pressed[0][4] = 1'b1;
        n = 0;
        while (key_code !== 5'd16 && n < 80) begin tick(); n++; end
        check("rst_rel_overrun_pre", 32'(overrun), 32'd1);
        repeat (5) tick();
        #2 rstn = 1'b0;
        #1 check_reset_outputs("rst_rel");
        pressed[0][4] = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        quiet("rst_rel_no_key", 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
